// File: rtl/inst_mem_responder.sv
// inst_mem_responder: instruction memory with 1-cycle fetch latency and a 2-entry in-order response FIFO.
// Faulted fetches still occupy a slot; flush drops pending responses, reset empties the FIFO but not memory.
module inst_mem_responder #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [31:0]   req_addr,
    output logic          req_ready,
    input  logic          flush,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_pc,
    output logic [31:0]   rsp_inst,
    output logic [1:0]    rsp_fault,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data
);
    logic [31:0]   mem [0:(1<<AW)-1];
    logic [1:0]    count;
    logic [31:0]   pc_q   [2];
    logic [31:0]   inst_q [2];
    logic [1:0]    fault_q[2];
    logic          accept;
    logic          pop;
    logic [1:0]    base;
    logic [1:0]    fault_n;
    logic [AW-1:0] idx;

    assign rsp_valid = count != 2'd0;
    assign req_ready = ~ld_en & ((count < 2'd2) | (rsp_valid & rsp_ready) | flush);
    assign accept    = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready & ~flush;
    assign idx       = req_addr[AW+1:2];
    // Kernel bit 31 is masked out before the range check.
    assign fault_n   = (req_addr[1:0] != 2'b00) ? 2'b01 :
                       (|((req_addr & 32'h7fff_ffff) >> (AW + 2))) ? 2'b10 : 2'b00;
    // Occupancy left after this cycle's pop or flush; the new entry lands right behind it.
    assign base      = flush ? 2'd0 : count - {1'b0, pop};

    assign rsp_pc    = rsp_valid ? pc_q[0]    : 32'd0;
    assign rsp_inst  = rsp_valid ? inst_q[0]  : 32'd0;
    assign rsp_fault = rsp_valid ? fault_q[0] : 2'b00;

    always_ff @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                pc_q[0]    <= pc_q[1];
                inst_q[0]  <= inst_q[1];
                fault_q[0] <= fault_q[1];
            end
            if (accept) begin
                pc_q[base[0]]    <= req_addr;
                inst_q[base[0]]  <= (fault_n != 2'b00) ? 32'd0 : mem[idx];
                fault_q[base[0]] <= fault_n;
            end
            count <= base + {1'b0, accept};
        end
    end
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb_inst_mem_responder: random fetch/flush/load/reset traffic scored against a queue-based reference model.
module tb_inst_mem_responder;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic [31:0]   req_addr = '0;
    logic          req_ready;
    logic          flush = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_pc;
    logic [31:0]   rsp_inst;
    logic [1:0]    rsp_fault;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0]   ld_data = '0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  fault;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mm [0:(1<<AW)-1];
    int          vectors = 0;
    int          miscompares = 0;

    inst_mem_responder #(.AW(AW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_pc(rsp_pc), .rsp_inst(rsp_inst), .rsp_fault(rsp_fault),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ready();
        return !ld_en && (q.size() < 2 || (q.size() != 0 && rsp_ready) || flush);
    endfunction

    function automatic rsp_t expect_of(input logic [31:0] a);
        rsp_t e;
        e.pc = a;
        if (a[1:0] != 2'b00) e.fault = 2'b01;
        else if ({1'b0, a[30:0]} >= (32'd1 << (AW + 2))) e.fault = 2'b10;
        else e.fault = 2'b00;
        e.inst = (e.fault == 2'b00) ? mm[a[AW+1:2]] : 32'd0;
        return e;
    endfunction

    // Reference model: expected responses are queued at the edge a request is accepted.
    always @(posedge clk) begin
        logic acc;
        rsp_t e;
        acc = req_valid && exp_ready();
        e = expect_of(req_addr);
        if (ld_en) mm[ld_addr] = ld_data;
        if (!reset) q.delete();
        else if (flush) begin
            q.delete();
            if (acc) q.push_back(e);
        end else begin
            if (q.size() != 0 && rsp_ready) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
    end

    // Monitor: compares whatever the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        rsp_t got;
        rsp_t want;
        got = {rsp_pc, rsp_inst, rsp_fault};
        want = (q.size() != 0) ? q[0] : '0;
        vectors++;
        if (rsp_valid !== (q.size() != 0)) begin
            miscompares++;
            $display("FAIL rsp_valid t=%0t got=%b want=%b", $time, rsp_valid, q.size() != 0);
        end
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL head t=%0t got pc=%h inst=%h fault=%b want pc=%h inst=%h fault=%b",
                     $time, got.pc, got.inst, got.fault, want.pc, want.inst, want.fault);
        end
        vectors++;
        if (req_ready !== exp_ready()) begin
            miscompares++;
            $display("FAIL req_ready t=%0t got=%b want=%b", $time, req_ready, exp_ready());
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic rr, input logic fl,
                         input logic ld, input logic [AW-1:0] la, input logic [31:0] ldd,
                         input logic rst);
        @(posedge clk);
        #1;
        req_valid = v; req_addr = a; rsp_ready = rr; flush = fl;
        ld_en = ld; ld_addr = la; ld_data = ldd; reset = rst;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = {$urandom_range(0, 1) == 1, 31'd0};
        if (r == 0) a = $urandom | 32'd1;
        else if (r == 1) a = a | (32'd1 << $urandom_range(AW + 2, 30)) | ({$urandom} & 32'h3fc);
        else if (r < 8) a = a | (32'($urandom_range(0, 15)) << 2);
        else a = a | (32'($urandom_range(0, (1 << AW) - 1)) << 2);
        return a;
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++)
            drive(0, 0, 0, 0, 1, AW'(i), $urandom, 0);
        drive(0, 0, 0, 0, 1, AW'(3), 32'h2408000A, 0);
        drive(0, 0, 0, 0, 1, AW'(1), 32'h0000_1111, 1);
        // Directed: basic fetch, backpressure, fault kinds, flush, load-then-read, reset with entries.
        drive(1, 32'h0000000C, 1, 0, 0, 0, 0, 1);
        drive(1, 32'h00000000, 0, 0, 0, 0, 0, 1);
        drive(1, 32'h00000004, 0, 0, 0, 0, 0, 1);
        drive(1, 32'h00000008, 0, 0, 0, 0, 0, 1);
        drive(1, 32'h00000008, 0, 0, 0, 0, 0, 1);
        drive(1, 32'h00000008, 1, 0, 0, 0, 0, 1);
        drive(1, 32'h00000402, 1, 0, 0, 0, 0, 1);
        drive(1, 32'h00000400, 1, 0, 0, 0, 0, 1);
        drive(1, 32'h80000004, 1, 0, 0, 0, 0, 1);
        drive(1, 32'h00000010, 0, 0, 0, 0, 0, 1);
        drive(1, 32'h00000014, 0, 0, 0, 0, 0, 1);
        drive(1, 32'h00000040, 1, 1, 0, 0, 0, 1);
        drive(1, 32'h00000020, 1, 0, 1, AW'(8), 32'hDEAD_BEEF, 1);
        drive(1, 32'h00000020, 1, 0, 0, 0, 0, 1);
        drive(1, 32'h00000004, 0, 0, 0, 0, 0, 1);
        drive(1, 32'h00000008, 0, 0, 0, 0, 0, 1);
        drive(0, 32'h00000000, 0, 0, 0, 0, 0, 0);
        drive(1, 32'h00000004, 1, 0, 0, 0, 0, 1);
        drive(0, 32'h00000000, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4000; i++)
            drive($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0,
                  AW'($urandom_range(0, 15)), $urandom, $urandom_range(0, 99) != 0);
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0, 0, 1);
        @(posedge clk);
        #6;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
